// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: signal bundle around the data-cache controller.
//   cpu_req_* / cpu_rsp_* : LSU request port (controller accepts requests)
//   mem_req_* / mem_rsp_* : memory bus (controller issues writebacks/refills)
// Modports:
//   master : LSU plus memory side (drives CPU requests, memory ready/response)
//   slave  : cache controller
interface dcache_ctrl_if #(
    parameter int unsigned ADDR_WD = 32,
    parameter int unsigned DATA_WD = 32
);
    localparam int unsigned BE_WD = DATA_WD / 8;

    logic               cpu_req_valid;
    logic               cpu_req_ready;
    logic               cpu_req_we;
    logic [ADDR_WD-1:0] cpu_req_addr;
    logic [DATA_WD-1:0] cpu_req_wdata;
    logic [BE_WD-1:0]   cpu_req_be;
    logic               cpu_rsp_valid;
    logic [DATA_WD-1:0] cpu_rsp_rdata;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_we;
    logic [ADDR_WD-1:0] mem_req_addr;
    logic [DATA_WD-1:0] mem_req_wdata;
    logic               mem_rsp_valid;
    logic [DATA_WD-1:0] mem_rsp_rdata;

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_be,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_be,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller,
// one data word per line. Owns the line array and sequences lookup, dirty-victim
// writeback and refill.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (invalidates every line)
//   bus  : dcache_ctrl_if.slave, LSU request/response and memory bus
//   perf_hit_cnt / perf_miss_cnt : saturating lookup counters, present only
//                                  when DCACHE_PERF_CNT_EN is defined
// Optional feature macro: DCACHE_PERF_CNT_EN
module dcache_ctrl #(
    parameter int unsigned ADDR_WD   = 32,
    parameter int unsigned DATA_WD   = 32,
    parameter int unsigned INDEX_WD  = 6,
    parameter int unsigned OFFSET_WD = 2
) (
    input  logic         clk,
    input  logic         rst,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]  perf_hit_cnt,
    output logic [31:0]  perf_miss_cnt,
`endif
    dcache_ctrl_if.slave bus
);
    localparam int unsigned TAG_WD    = ADDR_WD - INDEX_WD - OFFSET_WD;
    localparam int unsigned LINE_AW   = ADDR_WD - OFFSET_WD;
    localparam int unsigned BE_WD     = DATA_WD / 8;
    localparam int unsigned NUM_LINES = 1 << INDEX_WD;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [DATA_WD-1:0] data;
        logic [TAG_WD-1:0]  tag;
    } line_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        WB_REQ  = 3'd2,
        RF_REQ  = 3'd3,
        RF_WAIT = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                req_we_q;
    logic [LINE_AW-1:0]  req_line_q;
    logic [DATA_WD-1:0]  req_wdata_q;
    logic [BE_WD-1:0]    req_be_q;

    line_t               lines [NUM_LINES];

    logic [INDEX_WD-1:0] req_index;
    logic [TAG_WD-1:0]   req_tag;
    line_t               cur_line;
    logic                hit;
    logic                victim_dirty;
    logic                accept;
    logic                refill;

    // Offset bits never select data: one word per line.
    logic                unused_offset;
    assign unused_offset = ^bus.cpu_req_addr[OFFSET_WD-1:0];

    assign req_index    = req_line_q[INDEX_WD-1:0];
    assign req_tag      = req_line_q[LINE_AW-1:INDEX_WD];
    assign cur_line     = lines[req_index];
    assign hit          = cur_line.valid && (cur_line.tag == req_tag);
    assign victim_dirty = cur_line.valid && cur_line.dirty;
    assign accept       = bus.cpu_req_valid && bus.cpu_req_ready;
    assign refill       = (state_q == RF_WAIT) && bus.mem_rsp_valid;

    // Byte-enable merge of store data into an existing line word.
    function automatic logic [DATA_WD-1:0] merge_bytes(
        input logic [DATA_WD-1:0] old_data,
        input logic [DATA_WD-1:0] new_data,
        input logic [BE_WD-1:0]   be
    );
        logic [DATA_WD-1:0] res;
        res = old_data;
        for (int unsigned i = 0; i < BE_WD; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_d = IDLE;
                end else if (victim_dirty) begin
                    state_d = WB_REQ;
                end else begin
                    state_d = RF_REQ;
                end
            end
            WB_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RF_REQ;
                end
            end
            RF_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the selected line; stable while a
    // memory request waits for ready because nothing writes the array then.
    always_comb begin
        bus.cpu_req_ready = 1'b0;
        bus.cpu_rsp_valid = 1'b0;
        bus.cpu_rsp_rdata = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        case (state_q)
            IDLE: begin
                // Held low while reset is asserted, high the first cycle after.
                bus.cpu_req_ready = !rst;
            end
            LOOKUP: begin
                if (hit) begin
                    bus.cpu_rsp_valid = 1'b1;
                    bus.cpu_rsp_rdata = req_we_q ? '0 : cur_line.data;
                end
            end
            WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_addr  = {cur_line.tag, req_index, {OFFSET_WD{1'b0}}};
                bus.mem_req_wdata = cur_line.data;
            end
            RF_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {req_tag, req_index, {OFFSET_WD{1'b0}}};
            end
            default: ;
        endcase
    end

    // Request register and line array. Tag/data need no reset: valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we_q    <= 1'b0;
            req_line_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                lines[INDEX_WD'(i)].valid <= 1'b0;
                lines[INDEX_WD'(i)].dirty <= 1'b0;
            end
        end else begin
            if (accept) begin
                req_we_q    <= bus.cpu_req_we;
                req_line_q  <= bus.cpu_req_addr[ADDR_WD-1:OFFSET_WD];
                req_wdata_q <= bus.cpu_req_wdata;
                req_be_q    <= bus.cpu_req_be;
            end
            if ((state_q == LOOKUP) && hit && req_we_q) begin
                lines[req_index].data  <= merge_bytes(cur_line.data, req_wdata_q, req_be_q);
                lines[req_index].dirty <= 1'b1;
            end
            if (refill) begin
                lines[req_index] <= '{valid: 1'b1, dirty: 1'b0,
                                      data: bus.mem_rsp_rdata, tag: req_tag};
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Marks the lookup that follows a refill so it is not counted as a hit.
    logic post_refill_q;

    // Saturating hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            post_refill_q <= 1'b0;
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else begin
            if (refill) begin
                post_refill_q <= 1'b1;
            end else if (accept) begin
                post_refill_q <= 1'b0;
            end
            if (state_q == LOOKUP) begin
                if (hit && !post_refill_q && (perf_hit_cnt != 32'hFFFF_FFFF)) begin
                    perf_hit_cnt <= perf_hit_cnt + 32'd1;
                end
                if (!hit && (perf_miss_cnt != 32'hFFFF_FFFF)) begin
                    perf_miss_cnt <= perf_miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller for a direct-mapped, write-back, write-allocate data cache, one data word per line.
- The line format is the package cache line: valid, dirty, data word, tag. The CPU address splits as tag | index | byte offset.
- Sits between the LSU request port and the memory bus. Owns the tag/data line array and sequences lookup, dirty-victim writeback and refill.

Parameters:
- ADDR_WD, 32, CPU/memory byte address width.
- DATA_WD, 32, data word and line width.
- INDEX_WD, 6, index width; the array has 2**INDEX_WD lines.
- OFFSET_WD, 2, byte-offset width. TAG_WD = ADDR_WD-INDEX_WD-OFFSET_WD (derived, not overridable).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cpu_req_valid  in  1  CPU request valid
- cpu_req_ready  out  1  controller can accept a request
- cpu_req_we  in  1  1=store, 0=load
- cpu_req_addr  in  ADDR_WD  byte address
- cpu_req_wdata  in  DATA_WD  store data
- cpu_req_be  in  DATA_WD/8  store byte enables
- cpu_rsp_valid  out  1  one-cycle pulse: load data valid / store done
- cpu_rsp_rdata  out  DATA_WD  load data, 0 for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1=writeback, 0=refill read
- mem_req_addr  out  ADDR_WD  line address, offset bits 0
- mem_req_wdata  out  DATA_WD  victim data
- mem_rsp_valid  in  1  refill data valid
- mem_rsp_rdata  in  DATA_WD  refill data

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all valid and dirty bits cleared; request register cleared. Outputs cpu_req_ready, cpu_rsp_valid, mem_req_valid, mem_req_we = 0; cpu_rsp_rdata, mem_req_addr, mem_req_wdata = 0.
- The first cycle after rst deasserts has cpu_req_ready=1.
- States: IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT.
- IDLE: cpu_req_ready=1 only here. On valid&ready, latch we/addr/wdata/be and go to LOOKUP. cpu_req_valid without ready is ignored; the requester holds it.
- LOOKUP: index and tag come from the latched address. Hit = valid && tag match.
  - Load hit: cpu_rsp_valid=1, cpu_rsp_rdata = line data.
  - Store hit: per byte, bytes with be=1 take wdata; dirty=1; cpu_rsp_valid=1.
  - Either hit returns to IDLE. Hit latency is 1 cycle after acceptance; max throughput is one request per 2 cycles.
  - Miss with victim valid&dirty goes to WB_REQ; any other miss goes to RF_REQ.
- WB_REQ: mem_req_valid=1, we=1, addr = {victim tag, index, 0}, wdata = victim data. All four held stable until mem_req_ready. On handshake go to RF_REQ; the write completes on handshake with no response.
- RF_REQ: mem_req_valid=1, we=0, addr = {req tag, index, 0}. On handshake go to RF_WAIT.
- RF_WAIT: on mem_rsp_valid, write the line (valid=1, dirty=0, tag=req tag, data=mem_rsp_rdata) and go to LOOKUP, which then hits and responds. mem_rsp_valid in any other state is ignored.
- Miss latency with zero-wait memory: clean miss 4 cycles from acceptance to rsp; dirty miss 5 cycles.
- mem_req_valid is never dropped before its handshake, except by reset.
- Offset bits do not select data (one word per line). Misalignment is not checked.
- Reset mid-operation: the operation is abandoned and mem_req_valid is low the next cycle. All lines are invalidated and dirty data is discarded by design. No cpu_rsp_valid is issued for the abandoned request.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: adds outputs perf_hit_cnt and perf_miss_cnt, each 32 bits, reset 0.
  - perf_hit_cnt increments on each LOOKUP hit, excluding the post-refill lookup.
  - perf_miss_cnt increments on each LOOKUP miss.
  - Both saturate at 0xFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold load addr 0x0000_0104, memory returns 0xDEAD_BEEF, mem_req_ready=1, mem_rsp one cycle after handshake -> one mem read at addr 0x104, mem_req_we=0; cpu_rsp_valid 4 cycles after acceptance with rdata 0xDEAD_BEEF.
- Repeat load 0x104 -> no mem_req_valid; cpu_rsp_valid 1 cycle after acceptance, rdata 0xDEAD_BEEF.
- Store 0x104, wdata 0x1122_3344, be=4'b0011 -> next load returns 0xDEAD_3344 with no mem traffic.
- Load 0x204 (same index, tag 2) -> writeback at addr 0x104 with wdata 0xDEAD_3344, then refill read at addr 0x204, then response.
- Hold mem_req_ready=0 for 5 cycles in WB_REQ -> mem_req_valid, addr and wdata stable throughout; cpu_req_ready=0.
- Assert rst in RF_WAIT -> next cycle mem_req_valid=0 and state IDLE; a late mem_rsp_valid is ignored; load 0x204 misses again. With DCACHE_PERF_CNT_EN, both counters are 0 after reset.
